// File: rtl/key_expander.sv
// Iterative AES-128 key schedule: one round key per clock, streamed out and
// kept in an 11-entry buffer readable combinationally by round index.
module key_expander (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [127:0] key,
    input  logic [3:0]   rd_idx,
    output logic [127:0] round_key,
    output logic [3:0]   round_idx,
    output logic         key_valid,
    output logic         busy,
    output logic         ready,
    output logic         done,
    output logic [127:0] rd_key
);

    typedef enum logic [1:0] {S_IDLE, S_EXPAND, S_READY} state_t;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry 0 sits in the top byte of the packed table, so the byte offset is ~x.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX[{~x, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] rcon(input logic [3:0] r);
        logic [7:0] v;
        case (r)
            4'd1:    v = 8'h01;
            4'd2:    v = 8'h02;
            4'd3:    v = 8'h04;
            4'd4:    v = 8'h08;
            4'd5:    v = 8'h10;
            4'd6:    v = 8'h20;
            4'd7:    v = 8'h40;
            4'd8:    v = 8'h80;
            4'd9:    v = 8'h1b;
            4'd10:   v = 8'h36;
            default: v = 8'h00;
        endcase
        return v;
    endfunction

    state_t         r_state;
    logic [3:0]     r_cnt;
    logic [127:0]   r_buf [0:10];

    logic [31:0]    w_rot, w_sub, w_t;
    logic [31:0]    w_n0, w_n1, w_n2, w_n3;
    logic [127:0]   w_next;

    // During EXPAND round_key always equals buffer[r_cnt-1], so it feeds the round directly.
    always_comb begin
        w_rot  = {round_key[23:0], round_key[31:24]};
        w_sub  = {sbox(w_rot[31:24]), sbox(w_rot[23:16]), sbox(w_rot[15:8]), sbox(w_rot[7:0])};
        w_t    = w_sub ^ {rcon(r_cnt), 24'h0};
        w_n0   = round_key[127:96] ^ w_t;
        w_n1   = round_key[95:64]  ^ w_n0;
        w_n2   = round_key[63:32]  ^ w_n1;
        w_n3   = round_key[31:0]   ^ w_n2;
        w_next = {w_n0, w_n1, w_n2, w_n3};
    end

    always_comb begin
        rd_key = '0;
        for (int i = 0; i <= 10; i++)
            if (rd_idx == i[3:0]) rd_key = r_buf[i];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            for (int i = 0; i <= 10; i++) r_buf[i] <= '0;
            round_key <= '0;
            round_idx <= '0;
            key_valid <= 1'b0;
            busy      <= 1'b0;
            ready     <= 1'b0;
            done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_READY: begin
                    done <= 1'b0;
                    if (start) begin
                        r_buf[0]  <= key;
                        round_key <= key;
                        round_idx <= 4'd0;
                        key_valid <= 1'b1;
                        r_cnt     <= 4'd1;
                        busy      <= 1'b1;
                        ready     <= 1'b0;
                        r_state   <= S_EXPAND;
                    end else begin
                        key_valid <= 1'b0;
                    end
                end
                S_EXPAND: begin
                    for (int i = 1; i <= 10; i++)
                        if (r_cnt == i[3:0]) r_buf[i] <= w_next;
                    round_key <= w_next;
                    round_idx <= r_cnt;
                    key_valid <= 1'b1;
                    r_cnt     <= r_cnt + 4'd1;
                    if (r_cnt == 4'd10) begin
                        done    <= 1'b1;
                        ready   <= 1'b1;
                        busy    <= 1'b0;
                        r_state <= S_READY;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_key_expander.sv
// Bench for key_expander: a FIPS-197 style word-by-word key schedule, with the
// S-box derived from GF(2^8) inversion, predicts every streamed and buffered key.
module tb_key_expander;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [127:0] key;
    logic [3:0]   rd_idx;
    logic [127:0] round_key, rd_key;
    logic [3:0]   round_idx;
    logic         key_valid, busy, ready, done;

    int n_vec = 0, n_err = 0, n_done = 0, exp_done = 0;
    logic [7:0]   sb [0:255];
    logic [127:0] ref_rk [0:10];
    logic [127:0] ref_a  [0:10];

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    key_expander dut (
        .clk(clk), .rst(rst), .start(start), .key(key), .rd_idx(rd_idx),
        .round_key(round_key), .round_idx(round_idx), .key_valid(key_valid),
        .busy(busy), .ready(ready), .done(done), .rd_key(rd_key)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done === 1'b1) n_done++;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00, x = a, y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return 8'((v << n) | (v >> (8 - n)));
    endfunction

    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    task automatic ref_expand(input logic [127:0] k);
        logic [31:0] w [0:43];
        logic [31:0] tmp;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127 - 32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            tmp = w[i-1];
            if (i % 4 == 0) begin
                tmp = {tmp[23:0], tmp[31:24]};
                tmp = {sb[tmp[31:24]], sb[tmp[23:16]], sb[tmp[15:8]], sb[tmp[7:0]]} ^ {rc, 24'h0};
                rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
            end
            w[i] = w[i-4] ^ tmp;
        end
        for (int r = 0; r <= 10; r++) ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // One full expansion; with noisy set, start and key wiggle during EXPAND.
    task automatic run_exp(input logic [127:0] k, input bit noisy);
        ref_expand(k);
        @(negedge clk); start = 1'b1; key = k;
        for (int r = 0; r <= 10; r++) begin
            @(posedge clk); #1;
            start = noisy ? 1'($urandom) : 1'b0;
            if (noisy) key = {$urandom, $urandom, $urandom, $urandom};
            if (r == 10) start = 1'b0;
            rd_idx = 4'(r); #1;
            chk("round_key", round_key, ref_rk[r]);
            chk("round_idx", 128'(round_idx), 128'(r));
            chk("key_valid", 128'(key_valid), 128'(1));
            chk("done", 128'(done), 128'(r == 10));
            chk("busy", 128'(busy), 128'(r < 10));
            chk("rd_key_live", rd_key, ref_rk[r]);
        end
        exp_done++;
        @(posedge clk); #1;
        chk("ready", 128'(ready), 128'(1));
        chk("kv_idle", 128'(key_valid), 128'(0));
        chk("done_low", 128'(done), 128'(0));
        for (int i = 0; i < 16; i++) begin
            rd_idx = 4'(i); #1;
            chk("rd_key", rd_key, (i <= 10) ? ref_rk[i] : 128'h0);
        end
    endtask

    task automatic chk_zero_outputs();
        chk("rst_round_key", round_key, 128'h0);
        chk("rst_round_idx", 128'(round_idx), 128'(0));
        chk("rst_flags", 128'({key_valid, busy, ready, done}), 128'(0));
        for (int i = 0; i <= 10; i++) begin
            rd_idx = 4'(i); #1;
            chk("rst_rd_key", rd_key, 128'h0);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; key = '0; rd_idx = '0;
        build_sbox();
        #1 chk_zero_outputs();
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;

        run_exp(FIPS_KEY, 1'b0);
        rd_idx = 4'd1;  #1 chk("fips_r1", rd_key, 128'ha0fafe1788542cb123a339392a6c7605);
        rd_idx = 4'd10; #1 chk("fips_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        run_exp(128'h0, 1'b0);
        rd_idx = 4'd1;  #1 chk("zero_r1", rd_key, 128'h62636363626363636263636362636363);
        rd_idx = 4'd10; #1 chk("zero_r10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        for (int n = 0; n < 3; n++) run_exp({$urandom, $urandom, $urandom, $urandom}, 1'b1);

        // Abort at E5, then reset and start together (reset wins)
        @(negedge clk); start = 1'b1; key = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1 start = 1'b0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1;
        #1 chk_zero_outputs();
        start = 1'b1;
        @(posedge clk); #1;
        chk("rst_wins_kv", 128'(key_valid), 128'(0));
        chk("rst_wins_busy", 128'(busy), 128'(0));
        @(negedge clk); rst = 1'b0; start = 1'b0;
        run_exp(FIPS_KEY, 1'b0);
        rd_idx = 4'd10; #1 chk("abort_fips_r10", rd_key, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // Back-to-back: FIPS key then zero key with start held
        ref_expand(FIPS_KEY);
        for (int r = 0; r <= 10; r++) ref_a[r] = ref_rk[r];
        ref_expand(128'h0);
        @(negedge clk); start = 1'b1; key = FIPS_KEY;
        for (int j = 0; j < 22; j++) begin
            @(posedge clk); #1;
            chk("b2b_round_key", round_key, (j <= 10) ? ref_a[j] : ref_rk[j-11]);
            chk("b2b_round_idx", 128'(round_idx), 128'((j <= 10) ? j : j - 11));
            chk("b2b_key_valid", 128'(key_valid), 128'(1));
            chk("b2b_done", 128'(done), 128'(j == 10 || j == 21));
            chk("b2b_ready", 128'(ready), 128'(j == 10 || j == 21));
            if (j == 10) key = 128'h0;
            if (j == 11) start = 1'b0;
        end
        exp_done += 2;
        @(posedge clk); #1;
        chk("b2b_ready_hold", 128'(ready), 128'(1));
        chk("b2b_kv_idle", 128'(key_valid), 128'(0));
        rd_idx = 4'd10; #1 chk("b2b_rd10", rd_key, 128'hb4ef5bcb3e92e21123e951cf6f8f188e);

        chk("done_count", 128'(n_done), 128'(exp_done));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got %0d vectors want completion", n_vec);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/key_expander.md
# key_expander

Iterative AES-128 key schedule that sits directly upstream of `encryptor`. It turns one 128-bit cipher key into the 11 round keys (round 0..10), producing one per clock. Round keys are streamed out as they are produced and also kept in an internal 11-entry buffer, so the round datapath can read any round key by index. Expansion is sequential: four S-box lookups per cycle, no precomputed tables beyond the S-box.

## Interface
Parameters: none. The block is fixed at AES-128: 4-word key, 10 rounds.

Ports:
- `clk` in 1: single clock; all state is updated on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: request expansion of `key`; sampled only in IDLE or READY.
- `key` in 128: cipher key; `key[127:96]` = w0, `key[31:0]` = w3; sampled on the start edge only.
- `round_key` out 128: round key just produced (stream output).
- `round_idx` out 4: index 0..10 of `round_key`.
- `key_valid` out 1: `round_key`/`round_idx` are valid this cycle.
- `busy` out 1: high while in EXPAND.
- `ready` out 1: all 11 buffer entries are valid for the current key.
- `done` out 1: one-cycle pulse coincident with round 10.
- `rd_idx` in 4: combinational read address into the round-key buffer.
- `rd_key` out 128: contents of buffer entry `rd_idx`; 0 when `rd_idx` > 10.

## Operation
- States: IDLE, EXPAND, READY.
- IDLE:
  - `start`=1 at an edge → store `key` in buffer[0].
  - Drive `round_key`=`key`, `round_idx`=0, `key_valid`=1.
  - Round counter ← 1; go to EXPAND.
- EXPAND: each edge computes round r (r = counter) from buffer[r-1]:
  - t = SubWord(RotWord(w3)) ^ {Rcon[r], 24'h0}
  - w0' = w0 ^ t, w1' = w1 ^ w0', w2' = w2 ^ w1', w3' = w3 ^ w2'
  - Write the result to buffer[r] and drive it on `round_key`/`round_idx`=r with `key_valid`=1.
  - Increment counter.
- Rcon[1..10] = 01, 02, 04, 08, 10, 20, 40, 80, 1b, 36.
- Round 10 edge:
  - `done`=1 for that cycle only.
  - `ready` goes to 1 and holds.
  - State → READY.
- READY:
  - `key_valid`=0; buffer and `rd_key` are stable.
  - `start`=1 → same action as from IDLE: `ready` drops to 0 on that same edge and expansion restarts.
- `start` is ignored in EXPAND. `key` changes during EXPAND have no effect.
- All XORs are bitwise over 32-bit words; there is no arithmetic carry anywhere.
- Buffer entries not yet rewritten during a re-expansion may hold stale data. Consumers use only `rd_key` entries with index < the last `round_idx` streamed, or wait for `ready`.

## Timing
- Reset (async, immediate) clears everything:
  - state=IDLE, counter=0, all 11 buffer entries=0.
  - `round_key`=0, `round_idx`=0, `key_valid`=0, `busy`=0, `ready`=0, `done`=0.
  - `rd_key`=0 for every `rd_idx`.
- Call the start edge E0. Round r appears on the outputs after edge E0+r for r=0..10: 11 consecutive `key_valid` cycles with no gaps.
- `busy`=1 after E0 through E9 and 0 after E10.
- `done` and `ready` rise after E10. The latency from start to done is 10 cycles.
- `rd_key` is combinational from the buffer. buffer[r] reads back the round-r value starting the cycle after edge E0+r.
- Back-to-back: `start` held high in READY re-triggers on every READY edge. Keeping it high after E10 restarts on E11, so the next round 0 follows round 10 with no idle gap.
- `rst` during EXPAND aborts immediately; `done` never pulses for the aborted key.
- `rst` and `start` asserted together: reset wins.

## Test plan
- Reset: assert `rst` mid-run with `rd_idx`=0..10 → all outputs and every `rd_key` are 0; state is IDLE (a new `start` yields `round_idx`=0 on the next edge).
- FIPS-197 vector: `key`=2b7e151628aed2a6abf7158809cf4f3c, pulse `start` →
  - round 0 = key;
  - round 1 = a0fafe1788542cb123a339392a6c7605;
  - round 10 = d014f9a8c9ee2589e13f0cc8b6630ca6, with `done`=1 exactly 10 cycles after start.
- Zero key: `key`=0 →
  - round 1 = 62636363626363636263636362636363;
  - round 10 = b4ef5bcb3e92e21123e951cf6f8f188e;
  - afterwards `rd_idx`=1/10 returns the same values, and `rd_idx`=11..15 returns 0.
- `start` pulses and `key` changes during EXPAND → ignored. The stream stays gap-free with indices 0..10, and the results match the originally latched key.
- Reset abort: `rst` at E5, then `start` with the FIPS key → `done` never fires for the first key; the second run matches the FIPS vector exactly.
- Back-to-back restart: hold `start` high with the FIPS key, then the zero key → round 10 of the FIPS key is immediately followed by round 0 (value 0) of the zero key. `ready` is 0 for that cycle and returns after the second `done`.
